// File: rtl/dtcm_ahb_slave.sv
// Data TCM behind an AHB-Lite slave port: byte/half/word access, programmable
// wait states, write-to-read forwarding and two-cycle ERROR responses.

module dtcm_lane #(
  parameter int VEC_W = 8
) (
  input  logic             we,
  input  logic [VEC_W-1:0] wdata,
  input  logic [VEC_W-1:0] rdata,
  output logic [VEC_W-1:0] merged
);
  assign merged = we ? wdata : rdata;
endmodule

module dtcm_ahb_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hburst,
  input  logic [6:0]  hprot,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic        hresp,
  output logic [31:0] hrdata
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  typedef struct packed {
    logic                 vld;
    logic                 wr;
    logic [AW-1:0]        idx;
    logic [NUM_LANES-1:0] be;
  } dphase_t;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  dphase_t     dp_q, dp_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [31:0] mem [DEPTH_WORDS];

  logic                 in_range, aligned, legal, active, accept, wr_en, fwd;
  logic [AW-1:0]        a_idx;
  logic [NUM_LANES-1:0] a_be;
  logic [NUM_LANES-1:0][VEC_W-1:0] wd_lanes, rd_lanes, mg_lanes;
  logic [31:0]          wr_word;

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hmastlock};

  // Base is aligned to the array size, so range check is a tag compare.
  assign in_range = (haddr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign a_idx    = haddr[AW+1:2];
  assign active   = htrans[1];

  always_comb begin
    aligned = 1'b0;
    a_be    = '0;
    case (hsize)
      3'd0: begin aligned = 1'b1;            a_be = 4'b0001 << haddr[1:0]; end
      3'd1: begin aligned = ~haddr[0];       a_be = haddr[1] ? 4'b1100 : 4'b0011; end
      3'd2: begin aligned = haddr[1:0] == 0; a_be = 4'b1111; end
      default: ;
    endcase
  end

  assign legal  = in_range & aligned;
  assign hready = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign hresp  = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign accept = hready & active;
  assign wr_en  = hready & dp_q.vld & dp_q.wr;
  assign fwd    = wr_en && (dp_q.idx == a_idx);

  // Committed word = stored word with the enabled lanes replaced by hwdata.
  assign wd_lanes = hwdata;
  assign rd_lanes = mem[dp_q.idx];
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dtcm_lane #(.VEC_W(VEC_W)) u_lane (
      .we     (dp_q.be[i]),
      .wdata  (wd_lanes[i]),
      .rdata  (rd_lanes[i]),
      .merged (mg_lanes[i])
    );
  end
  assign wr_word = mg_lanes;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dp_d     = dp_q;
    hrdata_d = hrdata_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: ;
    endcase
    if (hready) begin
      dp_d = '0;
      if (accept) begin
        if (legal) begin
          dp_d.vld = 1'b1;
          dp_d.wr  = hwrite;
          dp_d.idx = a_idx;
          dp_d.be  = a_be;
          if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
          if (!hwrite) hrdata_d = fwd ? wr_word : mem[a_idx];
        end else begin
          state_d = S_ERR1;
        end
      end
    end
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dp_q     <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dp_q     <= dp_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Array is never reset; a write in flight during reset is dropped via dp_q.
  always_ff @(posedge hclk) begin
    if (wr_en) mem[dp_q.idx] <= wr_word;
  end

  assign hrdata = hrdata_q;
endmodule

// File: tb/tb_dtcm_ahb_slave.sv
// Bench for dtcm_ahb_slave: one zero-wait and one three-wait instance, directed
// cases plus random transfers checked against a byte-lane memory model.

module tb_dtcm_ahb_slave;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] LIMIT = 32'h0001_1000;

  logic             hclk;
  logic [1:0]       hrst, hwrite, hready, hresp;
  logic [1:0][31:0] haddr, hwdata, hrdata;
  logic [1:0][2:0]  hsize;
  logic [1:0][1:0]  htrans;
  logic [2:0]       hburst;
  logic [6:0]       hprot;
  logic             hmastlock;

  int n_assert = 0;
  int n_fail   = 0;
  int ws [2] = '{0, 3};
  logic [31:0] ref_mem [2][1024];

  dtcm_ahb_slave #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hrst(hrst[0]), .haddr(haddr[0]), .hwrite(hwrite[0]), .hsize(hsize[0]),
    .htrans(htrans[0]), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata[0]), .hready(hready[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));

  dtcm_ahb_slave #(.WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hrst(hrst[1]), .haddr(haddr[1]), .hwrite(hwrite[1]), .hsize(hsize[1]),
    .htrans(htrans[1]), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata[1]), .hready(hready[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] a, input logic [2:0] sz);
    return (a >= BASE) && (a < LIMIT) && (sz <= 3'd2) && ((a % (32'd1 << sz)) == 0);
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
    int idx;
    logic [31:0] mask;
    idx = int'((a - BASE) / 4);
    for (int b = 0; b < (1 << sz); b++) begin
      mask = 32'hFF << (((a % 4) + b) * 8);
      ref_mem[d][idx] = (ref_mem[d][idx] & ~mask) | (wd & mask);
    end
  endtask

  // Non-pipelined transfer; called and returns at posedge+1 with the bus idle.
  task automatic xfer(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd, input string tag);
    logic legal, done, bad_resp, f_resp;
    logic [31:0] f_rd, exp_rd;
    int exp_w, waits;
    legal  = is_legal(a, sz);
    exp_w  = legal ? ws[d] : 1;
    exp_rd = legal ? ref_mem[d][int'((a - BASE) / 4)] : 32'h0;
    haddr[d] = a; hwrite[d] = wr; hsize[d] = sz; htrans[d] = 2'd2;
    @(posedge hclk); #1;
    htrans[d] = 2'd0; haddr[d] = '0; hwrite[d] = 1'b0; hsize[d] = '0;
    hwdata[d] = (exp_w == 0) ? wd : $urandom;
    waits = 0; done = 1'b0; bad_resp = 1'b0; f_resp = 1'b0; f_rd = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge hclk);
      if (hready[d]) begin
        done = 1'b1; f_resp = hresp[d]; f_rd = hrdata[d];
      end else begin
        waits++;
        if (hresp[d] !== !legal) bad_resp = 1'b1;
        hwdata[d] = (waits == exp_w) ? wd : $urandom;
      end
    end
    @(posedge hclk); #1;
    chk({tag, "/done"}, done, 1'b1);
    chk({tag, "/waits"}, waits, exp_w);
    chk({tag, "/hresp"}, f_resp, !legal);
    chk({tag, "/wait_hresp"}, bad_resp, 1'b0);
    if (legal && !wr) chk({tag, "/hrdata"}, f_rd, exp_rd);
    if (legal && wr) model_write(d, a, sz, wd);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  sz;
    hrst = 2'b11; hwrite = '0; haddr = '0; hwdata = '0; hsize = '0; htrans = '0;
    hburst = 3'($urandom); hprot = 7'($urandom); hmastlock = 1'($urandom);
    @(posedge hclk);
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_hready", hready[d], 1'b1);
      chk("rst_hresp", hresp[d], 1'b0);
      chk("rst_hrdata", hrdata[d], 32'h0);
    end
    @(posedge hclk); #1;
    hrst = 2'b00;
    @(posedge hclk); #1;

    // BUSY is zero-wait OKAY with no access
    htrans[0] = 2'd1; haddr[0] = LIMIT;
    @(posedge hclk); #1;
    htrans[0] = 2'd0; haddr[0] = '0;
    @(negedge hclk);
    chk("busy_hready", hready[0], 1'b1);
    chk("busy_hresp", hresp[0], 1'b0);
    @(posedge hclk); #1;

    xfer(0, BASE, 1, 2, 32'hDEADBEEF, "w_base");
    xfer(0, BASE, 0, 2, 0, "r_base");
    chk("r_base_const", hrdata[0], 32'hDEADBEEF);

    xfer(0, BASE + 4, 1, 0, 32'h0000_0011, "wb4");
    xfer(0, BASE + 5, 1, 0, 32'h0000_2200, "wb5");
    xfer(0, BASE + 6, 1, 0, 32'h0033_0000, "wb6");
    xfer(0, BASE + 7, 1, 0, 32'h4400_0000, "wb7");
    xfer(0, BASE + 4, 0, 2, 0, "r_bytes");
    chk("r_bytes_const", hrdata[0], 32'h44332211);
    xfer(0, BASE + 6, 1, 1, 32'hAAAA_0000, "wh6");
    xfer(0, BASE + 4, 0, 2, 0, "r_half");
    chk("r_half_const", hrdata[0], 32'hAAAA2211);

    // back-to-back write then read of the same word: forwarding
    xfer(0, BASE + 8, 1, 2, 32'hCAFEF00D, "w_pre8");
    haddr[0] = BASE + 8; hwrite[0] = 1'b1; hsize[0] = 3'd2; htrans[0] = 2'd2;
    @(posedge hclk); #1;
    hwdata[0] = 32'h12345678; hwrite[0] = 1'b0;
    @(negedge hclk);
    chk("fwd_wr_hready", hready[0], 1'b1);
    @(posedge hclk); #1;
    htrans[0] = 2'd0;
    model_write(0, BASE + 8, 2, 32'h12345678);
    @(negedge hclk);
    chk("fwd_hready", hready[0], 1'b1);
    chk("fwd_hresp", hresp[0], 1'b0);
    chk("fwd_hrdata", hrdata[0], 32'h12345678);
    @(posedge hclk); #1;
    xfer(0, BASE + 8, 0, 2, 0, "r8");

    xfer(0, BASE + 2, 1, 2, 32'h0BAD0BAD, "err_misalign");
    xfer(0, LIMIT, 1, 2, 32'h0BAD0BAD, "err_limit");
    xfer(0, BASE, 1, 3, 32'h0BAD0BAD, "err_size");
    xfer(0, BASE, 0, 2, 0, "r_after_err");
    chk("r_after_err_const", hrdata[0], 32'hDEADBEEF);

    xfer(0, LIMIT - 4, 1, 2, 32'h01020304, "w_top");
    xfer(0, LIMIT - 1, 1, 0, 32'hEE00_0000, "wb_last");
    xfer(0, LIMIT - 4, 0, 2, 0, "r_top");
    chk("r_top_const", hrdata[0], 32'hEE020304);

    xfer(1, BASE + 16, 1, 2, 32'h0BADF00D, "ws_w");
    xfer(1, BASE + 16, 0, 2, 0, "ws_r");
    xfer(1, BASE + 16, 1, 2, 32'h600DCAFE, "ws_w2");
    xfer(1, BASE + 16, 0, 2, 0, "ws_r2");
    chk("ws_r2_const", hrdata[1], 32'h600DCAFE);
    xfer(1, BASE + 18, 1, 1, 32'h7777_0000, "ws_wh");
    xfer(1, BASE + 16, 0, 2, 0, "ws_r3");
    xfer(1, BASE + 17, 1, 1, 32'hFFFF_FFFF, "ws_err");
    xfer(1, BASE + 16, 0, 2, 0, "ws_r4");

    // reset in the middle of a waited write drops it
    xfer(1, BASE + 32, 1, 2, 32'h5555AAAA, "rst_init");
    haddr[1] = BASE + 32; hwrite[1] = 1'b1; hsize[1] = 3'd2; htrans[1] = 2'd2;
    @(posedge hclk); #1;
    htrans[1] = 2'd0; hwrite[1] = 1'b0; hwdata[1] = 32'hFFFFFFFF;
    @(negedge hclk);
    chk("mid_wait_hready", hready[1], 1'b0);
    #2 hrst[1] = 1'b1;
    #1;
    chk("mid_rst_hready", hready[1], 1'b1);
    chk("mid_rst_hresp", hresp[1], 1'b0);
    chk("mid_rst_hrdata", hrdata[1], 32'h0);
    @(posedge hclk); #1;
    hrst[1] = 1'b0;
    @(posedge hclk); #1;
    xfer(1, BASE + 32, 0, 2, 0, "r_after_rst");
    chk("r_after_rst_const", hrdata[1], 32'h5555AAAA);

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) xfer(d, BASE + 32'(w * 4), 1, 2, $urandom, "rnd_init");
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? BASE - 4 : LIMIT + 32'($urandom_range(0, 15));
        else a = BASE + 32'($urandom_range(0, 63));
        sz = 3'($urandom_range(0, 3));
        wd = $urandom;
        xfer(d, a, 1'($urandom_range(0, 1)), sz, wd, "rnd");
      end
      for (int w = 0; w < 16; w++) xfer(d, BASE + 32'(w * 4), 0, 2, 0, "rnd_final");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dtcm_ahb_slave.md
# dtcm_ahb_slave

AHB-Lite data tightly-coupled memory slave that sits directly downstream of the core's memory access unit. It accepts the core's mau_* bus transfers, stores data in an internal word-addressed array, and returns the dtcm_hready/dtcm_hresp/dtcm_hrdata response the core consumes. It supports byte, halfword and word accesses, programmable wait states, write-to-read forwarding and two-cycle ERROR responses for illegal transfers.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0001_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS).
- WAIT_STATES, 0, wait cycles per OKAY data phase (0..7).

- hclk  in  1  clock, all state on rising edge.
- hrst  in  1  asynchronous, active-high reset.
- haddr  in  32  address-phase byte address.
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  0 byte, 1 half, 2 word; others illegal.
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hburst, hprot(7), hmastlock  in  3/7/1  accepted, ignored.
- hwdata  in  32  write data, valid during data phase.
- hready  out  1  transfer-complete / address-phase-accept.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  32  read data, valid when hready=1 ending a read data phase.

## Operation
- Address phase sampled on an edge where hready=1; active when htrans is NONSEQ or SEQ. IDLE/BUSY: zero-wait OKAY, no access.
- Legal transfer: BASE_ADDR <= haddr < BASE_ADDR+4*DEPTH_WORDS, hsize<=2, natural alignment (half: haddr[0]=0; word: haddr[1:0]=0). Otherwise ERROR.
- FSM: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hready=1, hresp=0. Legal active transfer -> WAIT with counter=WAIT_STATES (if WAIT_STATES=0, data phase completes next cycle, stays in IDLE-equivalent completion). Illegal -> ERR1.
  - WAIT: hready=0, hresp=0, counter decrements; at 0 next cycle drives hready=1 (completion), returns to IDLE behaviour accepting the next address phase.
  - ERR1: hready=0, hresp=1 -> ERR2. ERR2: hready=1, hresp=1 -> IDLE behaviour. Address phase presented during ERR2 is accepted normally.
- Writes: committed on the edge ending the data phase (hready=1 cycle); byte enables from hsize and haddr[1:0] of the latched address phase, data taken from the matching hwdata lanes. ERROR transfers never write.
- Reads: hrdata register loaded on the address-phase-accepting edge with the full aligned word (all 4 lanes, no shifting/extension; core extracts lanes). Held until the next read is accepted.
- Forwarding: if a write completes on the same edge a read to the same word is accepted, hrdata gets the array word with the written bytes merged.
- Array contents are not reset.

## Timing
- Reset values: hready=1, hresp=0, hrdata=0, FSM IDLE, counter 0, latched address-phase regs cleared.
- OKAY latency: data phase = WAIT_STATES+1 cycles; back-to-back transfers pipeline with address phase N+1 overlapping data phase N.
- ERROR: exactly 2 data-phase cycles regardless of WAIT_STATES.
- hwdata is sampled only in the completing cycle; changes during wait cycles are ignored.
- Reset mid-transfer: pending write discarded, outputs return to reset values asynchronously.
- Address exactly BASE_ADDR+4*DEPTH_WORDS-1 (byte) legal; +4*DEPTH_WORDS illegal.

## Test plan
- Reset, WAIT_STATES=0: word write 0xDEADBEEF to BASE_ADDR, then read -> hrdata=0xDEADBEEF one cycle after read address phase, hresp=0, hready never low.
- Byte writes 0x11,0x22,0x33,0x44 to BASE_ADDR+4..+7, then halfword 0xAAAA to +6 -> word read at +4 returns 0xAAAA2211.
- Back-to-back write 0x12345678 to BASE_ADDR+8 then read of +8 in the immediately following address phase -> hrdata=0x12345678 (forwarding).
- WAIT_STATES=3: read -> hready low for 3 cycles, high on 4th with correct data; hwdata changed during waits, only final-cycle value written.
- Illegal: word access at BASE_ADDR+2, access at BASE_ADDR+4*DEPTH_WORDS, hsize=3 -> each gives hready=0/hresp=1 then hready=1/hresp=1; following read shows memory unchanged.
- Assert hrst during a WAIT-state write -> hready=1, hresp=0, hrdata=0 immediately; subsequent read shows old word.
